// File: rtl/hbm_cmd_gearbox.sv
// hbm_cmd_gearbox: buffers wide command-slot beats in a FIFO and replays them
// in arrival order as narrow sub-beats with backpressure and sticky overflow.
module hbm_cmd_gearbox #(
    parameter int SLOT_W = 64,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    dfi_clk,
    input  logic                    dfi_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*SLOT_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT*SLOT_W-1:0] out_data,
    output logic                    out_first,
    output logic                    out_last,
    output logic [CNT_W-1:0]        level,
    output logic                    overflow,
    input  logic                    clr_overflow
);
    localparam int R     = N_IN / N_OUT;
    localparam int SUB_W = (R > 1) ? $clog2(R) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IW    = N_IN * SLOT_W;
    localparam int OW    = N_OUT * SLOT_W;

    logic [IW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [SUB_W-1:0] sub;
    logic [IW-1:0]    cur;
    logic             push, pop_beat, pop_entry, sub_last;

    // Handshakes depend only on registered level, so a full FIFO refuses a push even while popping.
    always_comb begin
        in_ready  = level != CNT_W'(DEPTH);
        out_valid = level != '0;
        push      = in_valid & in_ready;
        pop_beat  = out_valid & out_ready;
        sub_last  = sub == SUB_W'(R - 1);
        pop_entry = pop_beat & sub_last;
        out_first = sub == '0;
        out_last  = sub_last;
        cur       = mem[rd_ptr];
        out_data  = OW'(cur >> (OW * int'(sub)));
    end

    always_ff @(posedge dfi_clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge dfi_clk or negedge dfi_rst_n) begin
        if (!dfi_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sub      <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_entry) rd_ptr <= rd_ptr + PTR_W'(1);
            if (pop_beat) sub <= sub_last ? '0 : sub + SUB_W'(1);
            level    <= level + CNT_W'(push) - CNT_W'(pop_entry);
            overflow <= (in_valid & ~in_ready) | (overflow & ~clr_overflow);
        end
    end
endmodule
